// File: rtl/mult_cell_sched_if.sv
// Request, response and multiplier-cell signals of mult_cell_sched.
// The slave modport is the scheduler side; the master modport is the requesters plus the cell.
interface mult_cell_sched_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req0_hi;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        req1_hi;
    logic        rsp0_valid;
    logic        rsp1_valid;
    logic [31:0] rsp_data;
    logic        busy;
    logic [31:0] cell_src1;
    logic [31:0] cell_src2;
    logic        cell_en;
    logic [31:0] cell_p1;
    logic [31:0] cell_p2;
    logic [31:0] cell_p3;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_hi,
        input  req1_valid, req1_a, req1_b, req1_hi,
        input  cell_p1, cell_p2, cell_p3,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, busy,
        output cell_src1, cell_src2, cell_en
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_hi,
        output req1_valid, req1_a, req1_b, req1_hi,
        output cell_p1, cell_p2, cell_p3,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, busy,
        input  cell_src1, cell_src2, cell_en
    );
endinterface

// File: rtl/mult_cell_sched.sv
// Round-robin sequencer sharing a three-partial-product multiplier cell between two requesters.
// Define MULT_SCHED_MULHI_EN to compile in the second cell pass that returns product bits [63:32].
module mult_cell_sched #(
    parameter int CELL_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    mult_cell_sched_if.slave  bus
);

`ifdef MULT_SCHED_MULHI_EN
    localparam int ACC_W = 64;
    localparam logic [1:0] HI_WAIT_LAST = 2'(CELL_LAT - 1);
    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT, COMBINE, ISSUE_HI, WAIT_HI, COMBINE_HI, DONE
    } state_t;
`else
    localparam int ACC_W = 32;
    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT, COMBINE, DONE
    } state_t;
`endif
    localparam logic [1:0] WAIT_LAST = 2'(CELL_LAT > 1 ? CELL_LAT - 2 : 0);

    state_t            state, state_nxt;
    logic              last_gnt;
    logic              gnt_id;
    logic              winner;
    logic              any_valid;
    logic [31:0]       a_q;
    logic [31:0]       b_q;
    logic [31:0]       rsp_hold;
    logic [31:0]       rsp_word;
    logic [ACC_W-1:0]  acc;
    logic [1:0]        cnt;
`ifdef MULT_SCHED_MULHI_EN
    logic              hi_q;
`endif

    // Low-pass combine: the cross-term sum keeps its carry (33 bits) before the shift.
    function automatic logic [63:0] combine_lo(input logic [31:0] p1, input logic [31:0] p2,
                                               input logic [31:0] p3);
        logic [32:0] mid;
        mid = {1'b0, p2} + {1'b0, p3};
        return {32'h0, p1} + ({31'h0, mid} << 16);
    endfunction

`ifdef MULT_SCHED_MULHI_EN
    function automatic logic [63:0] combine_hi(input logic [63:0] acc_in, input logic [31:0] p1);
        return acc_in + {p1, 32'h0};
    endfunction

    assign rsp_word = hi_q ? acc[63:32] : acc[31:0];
`else
    assign rsp_word = acc[31:0];
`endif

    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            winner = ~last_gnt;
        end else begin
            winner = bus.req1_valid;
        end
    end

    always_comb begin
        state_nxt      = state;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.rsp0_valid = 1'b0;
        bus.rsp1_valid = 1'b0;
        bus.rsp_data   = rsp_hold;
        bus.busy       = (state != IDLE);
        bus.cell_en    = 1'b0;
        bus.cell_src1  = 32'h0;
        bus.cell_src2  = 32'h0;
        unique case (state)
            IDLE: begin
                if (any_valid && !reset) begin
                    bus.req0_ready = ~winner;
                    bus.req1_ready = winner;
                    state_nxt      = ISSUE;
                end
            end
            ISSUE: begin
                bus.cell_en   = 1'b1;
                bus.cell_src1 = a_q;
                bus.cell_src2 = b_q;
                state_nxt     = (CELL_LAT == 1) ? COMBINE : WAIT;
            end
            WAIT: begin
                if (cnt == WAIT_LAST) state_nxt = COMBINE;
            end
            COMBINE: begin
`ifdef MULT_SCHED_MULHI_EN
                state_nxt = hi_q ? ISSUE_HI : DONE;
`else
                state_nxt = DONE;
`endif
            end
`ifdef MULT_SCHED_MULHI_EN
            ISSUE_HI: begin
                bus.cell_en   = 1'b1;
                bus.cell_src1 = {16'h0, a_q[31:16]};
                bus.cell_src2 = {16'h0, b_q[31:16]};
                state_nxt     = WAIT_HI;
            end
            // The high pass always waits CELL_LAT cycles, one more than the low pass.
            WAIT_HI: begin
                if (cnt == HI_WAIT_LAST) state_nxt = COMBINE_HI;
            end
            COMBINE_HI: state_nxt = DONE;
`endif
            DONE: begin
                bus.rsp_data   = rsp_word;
                bus.rsp0_valid = ~gnt_id;
                bus.rsp1_valid = gnt_id;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            gnt_id   <= 1'b0;
            a_q      <= 32'h0;
            b_q      <= 32'h0;
            acc      <= '0;
            cnt      <= 2'd0;
            rsp_hold <= 32'h0;
`ifdef MULT_SCHED_MULHI_EN
            hi_q     <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        a_q      <= winner ? bus.req1_a : bus.req0_a;
                        b_q      <= winner ? bus.req1_b : bus.req0_b;
                        gnt_id   <= winner;
                        last_gnt <= winner;
`ifdef MULT_SCHED_MULHI_EN
                        hi_q     <= winner ? bus.req1_hi : bus.req0_hi;
`endif
                    end
                end
                ISSUE:   cnt <= 2'd0;
                WAIT:    cnt <= cnt + 2'd1;
                COMBINE: acc <= ACC_W'(combine_lo(bus.cell_p1, bus.cell_p2, bus.cell_p3));
`ifdef MULT_SCHED_MULHI_EN
                ISSUE_HI:   cnt <= 2'd0;
                WAIT_HI:    cnt <= cnt + 2'd1;
                COMBINE_HI: acc <= combine_hi(acc, bus.cell_p1);
`endif
                DONE:    rsp_hold <= rsp_word;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_cell_sched.sv
// Bench for mult_cell_sched: two instances (CELL_LAT 1 and 3), each with a latency-accurate cell model,
// checked against an arithmetic reference of the product, latency and round-robin grant order.
module tb_mult_cell_sched;

    localparam int NI = 2;
`ifdef MULT_SCHED_MULHI_EN
    localparam bit MULHI_EN = 1'b1;
`else
    localparam bit MULHI_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        v0 [NI];
    logic        v1 [NI];
    logic        h0 [NI];
    logic        h1 [NI];
    logic [31:0] a0 [NI];
    logic [31:0] b0 [NI];
    logic [31:0] a1 [NI];
    logic [31:0] b1 [NI];
    logic        r0 [NI];
    logic        r1 [NI];
    logic        rv0 [NI];
    logic        rv1 [NI];
    logic        bsy [NI];
    logic        cen [NI];
    logic [31:0] rd [NI];
    logic [31:0] s1 [NI];
    logic [31:0] s2 [NI];

    int checks = 0;
    int errors = 0;
    int last_m [NI];

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int L = (g == 0) ? 1 : 3;
        mult_cell_sched_if bus ();

        assign bus.req0_valid = v0[g];
        assign bus.req0_a     = a0[g];
        assign bus.req0_b     = b0[g];
        assign bus.req0_hi    = h0[g];
        assign bus.req1_valid = v1[g];
        assign bus.req1_a     = a1[g];
        assign bus.req1_b     = b1[g];
        assign bus.req1_hi    = h1[g];
        assign r0[g]  = bus.req0_ready;
        assign r1[g]  = bus.req1_ready;
        assign rv0[g] = bus.rsp0_valid;
        assign rv1[g] = bus.rsp1_valid;
        assign bsy[g] = bus.busy;
        assign cen[g] = bus.cell_en;
        assign rd[g]  = bus.rsp_data;
        assign s1[g]  = bus.cell_src1;
        assign s2[g]  = bus.cell_src2;

        // Cell model: products appear L cycles after the enable cycle and hold afterwards.
        logic [3:0]       pv   = '0;
        logic [3:0][95:0] pd   = '0;
        logic [95:0]      held = '0;
        logic [95:0]      prod;
        logic [95:0]      cur;
        assign prod = {32'(bus.cell_src1[15:0]) * 32'(bus.cell_src2[15:0]),
                       32'(bus.cell_src1[15:0]) * 32'(bus.cell_src2[31:16]),
                       32'(bus.cell_src1[31:16]) * 32'(bus.cell_src2[15:0])};
        assign cur = pv[L-1] ? pd[L-1] : held;
        assign bus.cell_p1 = cur[95:64];
        assign bus.cell_p2 = cur[63:32];
        assign bus.cell_p3 = cur[31:0];
        always @(posedge clk) begin
            pv <= {pv[2:0], bus.cell_en};
            pd <= {pd[2:0], prod};
            if (pv[L-1]) held <= pd[L-1];
        end

        mult_cell_sched #(.CELL_LAT(L)) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus.slave)
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b, input logic hi);
        logic [63:0] p;
        p = {32'h0, a} * {32'h0, b};
        return (MULHI_EN && hi) ? p[63:32] : p[31:0];
    endfunction

    function automatic int ref_latency(input int lat, input logic hi);
        return (MULHI_EN && hi) ? 2 * lat + 4 : lat + 2;
    endfunction

    task automatic set_req(input int k, input int id, input logic vld, input logic [31:0] a,
                           input logic [31:0] b, input logic hi);
        if (id == 0) begin
            v0[k] = vld; a0[k] = a; b0[k] = b; h0[k] = hi;
        end else begin
            v1[k] = vld; a1[k] = a; b1[k] = b; h1[k] = hi;
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < NI; k++) begin
            set_req(k, 0, 1'b1, $urandom, $urandom, 1'b0);
            set_req(k, 1, 1'b1, $urandom, $urandom, 1'b1);
        end
        @(negedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (r0[k] !== 1'b0 || r1[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_ready inst %0d: ready0=%b ready1=%b, expected 0 0", k, r0[k], r1[k]);
            end
            checks++;
            if (bsy[k] !== 1'b0 || cen[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_busy_en inst %0d: busy=%b cell_en=%b, expected 0 0", k, bsy[k], cen[k]);
            end
            checks++;
            if (s1[k] !== 32'h0 || s2[k] !== 32'h0) begin
                errors++;
                $display("FAIL reset_src inst %0d: src1=%h src2=%h, expected 0 0", k, s1[k], s2[k]);
            end
            checks++;
            if (rd[k] !== 32'h0 || rv0[k] !== 1'b0 || rv1[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_rsp inst %0d: data=%h rsp0=%b rsp1=%b, expected 0 0 0", k, rd[k], rv0[k], rv1[k]);
            end
            set_req(k, 0, 1'b0, 32'h0, 32'h0, 1'b0);
            set_req(k, 1, 1'b0, 32'h0, 32'h0, 1'b0);
            last_m[k] = 1;
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (bsy[k] !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_busy inst %0d: busy=%b, expected 0", k, bsy[k]);
            end
        end
    endtask

    task automatic test_single_op(input int k, input int id, input logic [31:0] a, input logic [31:0] b,
                                  input logic hi);
        logic [31:0] exp_d, got_d, exp_s1, exp_s2;
        int lat, got, wrong, cen_n, cen_first, src_bad, busy_bad, exp_cen;
        exp_d = ref_result(a, b, hi);
        lat = ref_latency(lat_of(k), hi);
        exp_cen = (MULHI_EN && hi) ? 2 : 1;
        got = -1; wrong = 0; cen_n = 0; cen_first = -1; src_bad = 0; busy_bad = 0; got_d = 32'h0;
        @(negedge clk);
        set_req(k, id, 1'b1, a, b, hi);
        set_req(k, 1 - id, 1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        checks++;
        if ((id == 0 ? r0[k] : r1[k]) !== 1'b1 || (id == 0 ? r1[k] : r0[k]) !== 1'b0) begin
            errors++;
            $display("FAIL op_handshake inst %0d req%0d: ready0=%b ready1=%b", k, id, r0[k], r1[k]);
        end
        last_m[k] = id;
        for (int cyc = 1; cyc <= lat + 1; cyc++) begin
            @(negedge clk);
            if (cyc == 1) set_req(k, id, 1'b0, 32'h0, 32'h0, 1'b0);
            #1;
            exp_s1 = (cyc == 1) ? a : {16'h0, a[31:16]};
            exp_s2 = (cyc == 1) ? b : {16'h0, b[31:16]};
            if (cen[k] === 1'b1) begin
                cen_n++;
                if (cen_first < 0) cen_first = cyc;
                if (s1[k] !== exp_s1 || s2[k] !== exp_s2) src_bad++;
            end else if (s1[k] !== 32'h0 || s2[k] !== 32'h0) begin
                src_bad++;
            end
            if ((id == 0 ? rv0[k] : rv1[k]) === 1'b1) begin
                if (got < 0) begin
                    got = cyc; got_d = rd[k];
                end else begin
                    wrong++;
                end
            end
            if ((id == 0 ? rv1[k] : rv0[k]) !== 1'b0) wrong++;
            if (bsy[k] !== (cyc <= lat)) busy_bad++;
        end
        checks++;
        if (got != lat) begin
            errors++;
            $display("FAIL op_latency inst %0d a=%h b=%h hi=%b: cycle %0d, expected %0d", k, a, b, hi, got, lat);
        end
        checks++;
        if (got_d !== exp_d) begin
            errors++;
            $display("FAIL op_data inst %0d a=%h b=%h hi=%b: %h, expected %h", k, a, b, hi, got_d, exp_d);
        end
        checks++;
        if (rd[k] !== exp_d) begin
            errors++;
            $display("FAIL op_hold inst %0d: rsp_data=%h after DONE, expected %h", k, rd[k], exp_d);
        end
        checks++;
        if (wrong != 0) begin
            errors++;
            $display("FAIL op_rsp_id inst %0d req%0d: %0d stray pulses, expected 0", k, id, wrong);
        end
        checks++;
        if (cen_n != exp_cen || cen_first != 1 || src_bad != 0) begin
            errors++;
            $display("FAIL op_cell inst %0d: en cycles %0d first %0d bad src %0d, expected %0d 1 0",
                     k, cen_n, cen_first, src_bad, exp_cen);
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL op_busy inst %0d: %0d wrong busy cycles, expected 0", k, busy_bad);
        end
    endtask

    task automatic test_directed();
        test_single_op(0, 0, 32'd3, 32'd5, 1'b0);
        test_single_op(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        test_single_op(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        test_single_op(0, 0, 32'h0001_0000, 32'h0001_0000, 1'b0);
        test_single_op(0, 0, 32'h0001_0000, 32'h0001_0000, 1'b1);
        test_single_op(0, 1, 32'hFFFF_0001, 32'h8000_FFFF, 1'b1);
        test_single_op(1, 0, 32'h0000_1234, 32'h0000_0010, 1'b0);
        test_single_op(1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    endtask

    task automatic test_random(input int k, input int n);
        logic [31:0] a, b;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 3))
                0: begin a = 32'hFFFF_FFFF; b = $urandom; end
                1: begin a = {16'($urandom), 16'hFFFF}; b = {16'hFFFF, 16'($urandom)}; end
                default: begin a = $urandom; b = $urandom; end
            endcase
            test_single_op(k, $urandom_range(0, 1), a, b, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_round_robin(input int k);
        logic [31:0] oa [2];
        logic [31:0] ob [2];
        logic        oh [2];
        logic [31:0] due_d;
        logic [1:0]  rdy;
        int grants, cyc, due, due_id, last_done, upd, exp_w;
        grants = 0; cyc = 0; due = -1; due_id = 0; last_done = -1; upd = -1; due_d = 32'h0;
        for (int i = 0; i < 2; i++) begin
            oa[i] = $urandom; ob[i] = $urandom; oh[i] = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        set_req(k, 0, 1'b1, oa[0], ob[0], oh[0]);
        set_req(k, 1, 1'b1, oa[1], ob[1], oh[1]);
        while ((grants < 4 || due >= 0) && cyc < 200) begin
            #1;
            rdy = {r1[k], r0[k]};
            if (rv0[k] === 1'b1 || rv1[k] === 1'b1) begin
                checks++;
                if (cyc != due || {rv1[k], rv0[k]} !== (due_id == 1 ? 2'b10 : 2'b01) || rd[k] !== due_d) begin
                    errors++;
                    $display("FAIL rr_rsp inst %0d cycle %0d: rsp1/rsp0=%b data=%h, expected cycle %0d req%0d data %h",
                             k, cyc, {rv1[k], rv0[k]}, rd[k], due, due_id, due_d);
                end
                checks++;
                if (rdy !== 2'b00) begin
                    errors++;
                    $display("FAIL rr_done_ready inst %0d: ready=%b in DONE, expected 00", k, rdy);
                end
                last_done = cyc;
                due = -1;
            end else if (cyc == due) begin
                checks++;
                errors++;
                $display("FAIL rr_missing inst %0d: no rsp at cycle %0d, expected req%0d", k, cyc, due_id);
                due = -1;
            end
            if (rdy !== 2'b00) begin
                exp_w = (last_m[k] == 1) ? 0 : 1;
                checks++;
                if (rdy !== (exp_w == 1 ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL rr_grant inst %0d grant %0d: ready1/ready0=%b, expected req%0d", k, grants, rdy, exp_w);
                end
                if (grants > 0) begin
                    checks++;
                    if (cyc != last_done + 1) begin
                        errors++;
                        $display("FAIL rr_gap inst %0d: grant at cycle %0d, expected %0d", k, cyc, last_done + 1);
                    end
                end
                last_m[k] = exp_w;
                grants++;
                due = cyc + ref_latency(lat_of(k), oh[exp_w]);
                due_d = ref_result(oa[exp_w], ob[exp_w], oh[exp_w]);
                due_id = exp_w;
                upd = exp_w;
            end
            @(negedge clk);
            cyc++;
            if (upd >= 0) begin
                if (grants >= 4) begin
                    set_req(k, 0, 1'b0, 32'h0, 32'h0, 1'b0);
                    set_req(k, 1, 1'b0, 32'h0, 32'h0, 1'b0);
                end else begin
                    oa[upd] = $urandom; ob[upd] = $urandom; oh[upd] = 1'($urandom_range(0, 1));
                    set_req(k, upd, 1'b1, oa[upd], ob[upd], oh[upd]);
                end
                upd = -1;
            end
        end
        if (cyc >= 200) begin
            checks++;
            errors++;
            $display("FAIL rr_timeout inst %0d: %0d grants after %0d cycles, expected 4", k, grants, cyc);
        end
        set_req(k, 0, 1'b0, 32'h0, 32'h0, 1'b0);
        set_req(k, 1, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_reset_abort(input int k);
        logic [31:0] na, nb, exp_d, got_d;
        int stray, rdy_bad, got, lat;
        stray = 0; rdy_bad = 0; got = -1; got_d = 32'h0;
        na = $urandom; nb = $urandom;
        exp_d = ref_result(na, nb, 1'b0);
        lat = ref_latency(lat_of(k), 1'b0);
        @(negedge clk);
        set_req(k, 0, 1'b1, $urandom, $urandom, 1'b0);
        #1;
        checks++;
        if (r0[k] !== 1'b1) begin
            errors++;
            $display("FAIL abort_accept inst %0d: ready0=%b, expected 1", k, r0[k]);
        end
        @(negedge clk);
        set_req(k, 0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        #1;
        checks++;
        if (bsy[k] !== 1'b1) begin
            errors++;
            $display("FAIL abort_wait_busy inst %0d: busy=%b, expected 1", k, bsy[k]);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bsy[k] !== 1'b0) begin
            errors++;
            $display("FAIL abort_async inst %0d: busy=%b during reset, expected 0", k, bsy[k]);
        end
        set_req(k, 0, 1'b1, na, nb, 1'b0);
        set_req(k, 1, 1'b1, $urandom, $urandom, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            if (rv0[k] !== 1'b0 || rv1[k] !== 1'b0) stray++;
            if (r0[k] !== 1'b0 || r1[k] !== 1'b0) rdy_bad++;
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NI; i++) last_m[i] = 1;
        #1;
        checks++;
        if (r0[k] !== 1'b1 || r1[k] !== 1'b0 || rdy_bad != 0) begin
            errors++;
            $display("FAIL abort_ready inst %0d: ready0=%b ready1=%b, %0d ready cycles in reset, expected 1 0 0",
                     k, r0[k], r1[k], rdy_bad);
        end
        last_m[k] = 0;
        for (int cyc = 1; cyc <= lat + 1; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                set_req(k, 0, 1'b0, 32'h0, 32'h0, 1'b0);
                set_req(k, 1, 1'b0, 32'h0, 32'h0, 1'b0);
            end
            #1;
            if (rv0[k] === 1'b1 && got < 0) begin
                got = cyc; got_d = rd[k];
            end else if (rv0[k] !== 1'b0 || rv1[k] !== 1'b0) begin
                stray++;
            end
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL abort_stray inst %0d: %0d unexpected rsp pulses, expected 0", k, stray);
        end
        checks++;
        if (got != lat || got_d !== exp_d) begin
            errors++;
            $display("FAIL abort_next_op inst %0d: cycle %0d data %h, expected cycle %0d data %h",
                     k, got, got_d, lat, exp_d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NI; k++) begin
            set_req(k, 0, 1'b0, 32'h0, 32'h0, 1'b0);
            set_req(k, 1, 1'b0, 32'h0, 32'h0, 1'b0);
            last_m[k] = 1;
        end
        test_reset();
        test_directed();
        test_random(0, 12);
        test_random(1, 8);
        test_single_op(0, 1, $urandom, $urandom, 1'b0);
        test_round_robin(0);
        test_single_op(1, 1, $urandom, $urandom, 1'b1);
        test_round_robin(1);
        test_reset_abort(1);
        test_round_robin(0);
        test_round_robin(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
